// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C byte receiver and its master.
package i2c_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    ACK
  } state_t;

  localparam int DEFAULT_MESSAGE_LENGTH = 8;

  function automatic int count_width(input int message_length);
    return $clog2(message_length + 1);
  endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// Multi-flop synchronizer for one I2C line, with a delayed copy for edge detection.
module i2c_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic line,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain_reg;
  logic                   prev_reg;

  if (SYNC_STAGES < 2 || SYNC_STAGES > 3) begin : g_bad_stages
    $error("i2c_line_sync: SYNC_STAGES must be 2 or 3");
  end

  // Reset to 1 so an idle bus is not mistaken for an edge after reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      chain_reg <= '1;
      prev_reg  <= 1'b1;
    end else begin
      chain_reg <= {chain_reg[SYNC_STAGES-2:0], line};
      prev_reg  <= chain_reg[SYNC_STAGES-1];
    end
  end

  assign level = chain_reg[SYNC_STAGES-1];
  assign rise  = level & ~prev_reg;
  assign fall  = ~level & prev_reg;

endmodule

// File: rtl/i2c_byte_receiver.sv
// Receive-only I2C slave: START/STOP detection and MSB-first word capture.
// Optional open-drain ACK request output is enabled by I2C_RX_ACK_DRIVE_EN.
module i2c_byte_receiver
  import i2c_pkg::*;
#(
  parameter int MESSAGE_LENGTH = DEFAULT_MESSAGE_LENGTH,
  parameter int ACK_SLOT       = 1,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      sda,
  input  logic                      scl,
  output logic [MESSAGE_LENGTH-1:0] data_out,
  output logic                      data_valid,
  output logic                      busy,
  output logic                      frame_error
`ifdef I2C_RX_ACK_DRIVE_EN
  ,
  output logic                      sda_ack_n
`endif
);

  localparam int CW = count_width(MESSAGE_LENGTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(MESSAGE_LENGTH - 1);

  if (MESSAGE_LENGTH < 2) begin : g_bad_length
    $error("i2c_byte_receiver: MESSAGE_LENGTH must be at least 2");
  end

`ifdef I2C_RX_ACK_DRIVE_EN
  if (ACK_SLOT == 0) begin : g_bad_ack_cfg
    $error("i2c_byte_receiver: ACK drive requires ACK_SLOT=1");
  end
`endif

  logic s_scl, scl_rise, scl_fall;
  logic s_sda, sda_rise, sda_fall;

  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_scl_sync (
    .clk  (clk),
    .reset(reset),
    .line (scl),
    .level(s_scl),
    .rise (scl_rise),
    .fall (scl_fall)
  );

  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sda_sync (
    .clk  (clk),
    .reset(reset),
    .line (sda),
    .level(s_sda),
    .rise (sda_rise),
    .fall (sda_fall)
  );

  state_t                    state_reg, state_next;
  logic [CW-1:0]             count_reg;
  logic [MESSAGE_LENGTH-2:0] shift_reg;
  logic                      bit_open_reg;
  logic                      ack_rise_seen_reg;
  logic                      start_cond, stop_cond;
  logic                      bit_done;
  logic                      partial;
  logic [MESSAGE_LENGTH-1:0] word;

  assign start_cond = sda_fall & s_scl;
  assign stop_cond  = sda_rise & s_scl;
  assign word       = {shift_reg, s_sda};
  assign bit_done   = (state_reg == RECV) & scl_rise & ~start_cond & ~stop_cond
                    & (count_reg == LAST_BIT);

  // The scl pulse that carries a STOP or repeated START is sampled as a bit
  // before the sda edge reveals its purpose; that single open bit is not a
  // partial word.
  assign partial = count_reg > CW'(bit_open_reg);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (stop_cond) begin
      state_next = IDLE;
    end else if (start_cond) begin
      state_next = RECV;
    end else begin
      case (state_reg)
        RECV:    if (bit_done && ACK_SLOT != 0) state_next = ACK;
        ACK:     if (scl_fall && ack_rise_seen_reg) state_next = RECV;
        default: state_next = state_reg;
      endcase
    end
  end

  always_comb begin
    busy = (state_reg != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_reg         <= '0;
      shift_reg         <= '0;
      bit_open_reg      <= 1'b0;
      ack_rise_seen_reg <= 1'b0;
      data_out          <= '0;
      data_valid        <= 1'b0;
      frame_error       <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      if (stop_cond) begin
        if (state_reg == RECV && partial) frame_error <= 1'b1;
        count_reg         <= '0;
        bit_open_reg      <= 1'b0;
        ack_rise_seen_reg <= 1'b0;
      end else if (start_cond) begin
        if (state_reg != IDLE && partial) frame_error <= 1'b1;
        count_reg         <= '0;
        bit_open_reg      <= 1'b0;
        ack_rise_seen_reg <= 1'b0;
      end else begin
        if (scl_fall) bit_open_reg <= 1'b0;
        case (state_reg)
          RECV: begin
            if (scl_rise) begin
              shift_reg    <= word[MESSAGE_LENGTH-2:0];
              bit_open_reg <= 1'b1;
              if (count_reg == LAST_BIT) begin
                data_out   <= word;
                data_valid <= 1'b1;
                count_reg  <= '0;
              end else begin
                count_reg <= count_reg + CW'(1);
              end
            end
          end
          ACK: begin
            if (scl_rise) begin
              ack_rise_seen_reg <= 1'b1;
            end else if (scl_fall && ack_rise_seen_reg) begin
              ack_rise_seen_reg <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef I2C_RX_ACK_DRIVE_EN
  // Pull low from the fall that ends the last data bit to the fall ending the ACK pulse.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sda_ack_n <= 1'b1;
    end else if (start_cond || stop_cond) begin
      sda_ack_n <= 1'b1;
    end else if (state_reg == ACK && scl_fall) begin
      sda_ack_n <= ack_rise_seen_reg;
    end
  end
`endif

endmodule

// File: tb/tb_i2c_byte_receiver.sv
// Directed, table-driven bench for i2c_byte_receiver (I2C_RX_ACK_DRIVE_EN adds ACK-drive checks).
module tb_i2c_byte_receiver;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       sda = 1'b1;
  logic       scl = 1'b1;
  logic [7:0] data_out;
  logic       data_valid;
  logic       busy;
  logic       frame_error;
`ifdef I2C_RX_ACK_DRIVE_EN
  logic       sda_ack_n;
  logic       ack_mid;
`endif

  always #5 clk = ~clk;

  i2c_byte_receiver dut (
    .clk        (clk),
    .reset      (reset),
    .sda        (sda),
    .scl        (scl),
    .data_out   (data_out),
    .data_valid (data_valid),
    .busy       (busy),
    .frame_error(frame_error)
`ifdef I2C_RX_ACK_DRIVE_EN
    ,
    .sda_ack_n  (sda_ack_n)
`endif
  );

  int         checks = 0;
  int         errors = 0;
  logic [7:0] rx_q[$];
  bit         track_busy = 1'b0;
  bit         busy_dropped = 1'b0;

  always @(negedge clk) begin
    if (data_valid) rx_q.push_back(data_out);
    if (track_busy && !busy) busy_dropped = 1'b1;
  end

  typedef struct {
    logic [7:0] word;
    int         nbits;
    int         exp_nvalid;
    logic [7:0] exp_data;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  function automatic logic [7:0] q_at(input int i);
    if (i < rx_q.size()) return rx_q[i];
    return 8'hxx;
  endfunction

  task automatic wait_q();
    repeat (4) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    sda = b;
    wait_q();
    scl = 1'b1;
    wait_q();
    wait_q();
    scl = 1'b0;
    repeat (2) @(negedge clk);
`ifdef I2C_RX_ACK_DRIVE_EN
    ack_mid = sda_ack_n;
`endif
    repeat (2) @(negedge clk);
  endtask

  task automatic ack_slot();
`ifdef I2C_RX_ACK_DRIVE_EN
    check("ack_n_before_fall", ack_mid, 1);
    check("ack_n_after_fall", sda_ack_n, 0);
`endif
    sda = 1'b1;
    wait_q();
    scl = 1'b1;
    wait_q();
`ifdef I2C_RX_ACK_DRIVE_EN
    check("ack_n_slot_high", sda_ack_n, 0);
`endif
    wait_q();
    scl = 1'b0;
    repeat (2) @(negedge clk);
`ifdef I2C_RX_ACK_DRIVE_EN
    check("ack_n_before_end", sda_ack_n, 0);
`endif
    @(negedge clk);
`ifdef I2C_RX_ACK_DRIVE_EN
    check("ack_n_released", sda_ack_n, 1);
`endif
    @(negedge clk);
  endtask

  task automatic send_word(input logic [7:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      send_bit(w[7-i]);
`ifdef I2C_RX_ACK_DRIVE_EN
      if (i == 3) check("ack_n_data_bit", sda_ack_n, 1);
`endif
    end
    if (n == 8) ack_slot();
  endtask

  task automatic do_start();
    sda = 1'b0;
    wait_q();
    scl = 1'b0;
    wait_q();
  endtask

  task automatic do_stop();
    sda = 1'b0;
    wait_q();
    scl = 1'b1;
    wait_q();
    sda = 1'b1;
    wait_q();
  endtask

  task automatic do_rstart();
    sda = 1'b1;
    wait_q();
    scl = 1'b1;
    wait_q();
    sda = 1'b0;
    wait_q();
    scl = 1'b0;
    wait_q();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data_out"}, data_out, 0);
    check({tag, "_data_valid"}, data_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_frame_error"}, frame_error, 0);
`ifdef I2C_RX_ACK_DRIVE_EN
    check({tag, "_sda_ack_n"}, sda_ack_n, 1);
`endif
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    scl = 1'b1;
    sda = 1'b1;
    repeat (4) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b1;
    wait_q();
    rx_q.delete();
  endtask

  initial begin
    vecs[0] = '{word: 8'h5F, nbits: 8, exp_nvalid: 1, exp_data: 8'h5F, exp_ferr: 1'b0};
    vecs[1] = '{word: 8'h00, nbits: 8, exp_nvalid: 1, exp_data: 8'h00, exp_ferr: 1'b0};
    vecs[2] = '{word: 8'hFF, nbits: 8, exp_nvalid: 1, exp_data: 8'hFF, exp_ferr: 1'b0};
    vecs[3] = '{word: 8'hA5, nbits: 3, exp_nvalid: 0, exp_data: 8'h00, exp_ferr: 1'b1};
    vecs[4] = '{word: 8'h81, nbits: 6, exp_nvalid: 0, exp_data: 8'h00, exp_ferr: 1'b1};
    vecs[5] = '{word: 8'hC3, nbits: 1, exp_nvalid: 0, exp_data: 8'h00, exp_ferr: 1'b1};

    for (int v = 0; v < 6; v++) begin
      apply_reset();
      do_start();
      check($sformatf("v%0d_busy_after_start", v), busy, 1);
      send_word(vecs[v].word, vecs[v].nbits);
      do_stop();
      check($sformatf("v%0d_nvalid", v), rx_q.size(), vecs[v].exp_nvalid);
      if (vecs[v].exp_nvalid > 0)
        check($sformatf("v%0d_data", v), q_at(0), vecs[v].exp_data);
      else
        check($sformatf("v%0d_data_kept", v), data_out, 0);
      check($sformatf("v%0d_frame_error", v), frame_error, vecs[v].exp_ferr);
      check($sformatf("v%0d_busy_after_stop", v), busy, 0);
    end

    // Latency from the pin-level rise of the last bit to data_valid.
    apply_reset();
    do_start();
    for (int i = 0; i < 7; i++) send_bit(8'hB7 >> (7 - i));
    sda = 1'b1;
    wait_q();
    scl = 1'b1;
    repeat (2) @(negedge clk);
    check("lat_valid_early", data_valid, 0);
    @(negedge clk);
    check("lat_valid_on_time", data_valid, 1);
    check("lat_data", data_out, 8'hB7);
    @(negedge clk);
    check("lat_valid_one_cycle", data_valid, 0);
    repeat (4) @(negedge clk);
    scl = 1'b0;
    repeat (4) @(negedge clk);
    ack_slot();
    do_stop();
    check("lat_nvalid", rx_q.size(), 1);

    // Back-to-back words in one transaction.
    apply_reset();
    do_start();
    busy_dropped = 1'b0;
    track_busy = 1'b1;
    send_word(8'h95, 8);
    send_word(8'hF0, 8);
    send_word(8'h0F, 8);
    track_busy = 1'b0;
    do_stop();
    check("b2b_nvalid", rx_q.size(), 3);
    check("b2b_word0", q_at(0), 8'h95);
    check("b2b_word1", q_at(1), 8'hF0);
    check("b2b_word2", q_at(2), 8'h0F);
    check("b2b_busy_dropped", busy_dropped, 0);
    check("b2b_frame_error", frame_error, 0);

    // Aborted word, then a good word: frame_error must remain set.
    apply_reset();
    do_start();
    send_word(8'hA5, 3);
    do_stop();
    check("abort_nvalid", rx_q.size(), 0);
    check("abort_frame_error", frame_error, 1);
    check("abort_busy", busy, 0);
    do_start();
    send_word(8'h3C, 8);
    do_stop();
    check("after_abort_nvalid", rx_q.size(), 1);
    check("after_abort_data", q_at(0), 8'h3C);
    check("after_abort_frame_error_sticky", frame_error, 1);

    // Reset mid-word, then a full word.
    apply_reset();
    do_start();
    send_word(8'hE6, 5);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("midreset");
    scl = 1'b1;
    sda = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    wait_q();
    do_start();
    send_word(8'h81, 8);
    do_stop();
    check("midreset_nvalid", rx_q.size(), 1);
    check("midreset_data", q_at(0), 8'h81);
    check("midreset_frame_error", frame_error, 0);

    // Repeated START after a complete word.
    apply_reset();
    do_start();
    busy_dropped = 1'b0;
    track_busy = 1'b1;
    send_word(8'h12, 8);
    do_rstart();
    send_word(8'h34, 8);
    track_busy = 1'b0;
    do_stop();
    check("rstart_nvalid", rx_q.size(), 2);
    check("rstart_word0", q_at(0), 8'h12);
    check("rstart_word1", q_at(1), 8'h34);
    check("rstart_frame_error", frame_error, 0);
    check("rstart_busy_dropped", busy_dropped, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_byte_receiver.md
Name: i2c_byte_receiver

Overview:
- Receive-only I2C bus monitor and slave that sits directly downstream of the master on the sda/scl pair.
- Oversamples scl and sda with the system clock, detects START and STOP conditions, and shifts in MESSAGE_LENGTH bits MSB-first on scl rising edges.
- Presents each completed word on a parallel bus with a one-cycle valid strobe for the next consumer stage.

Parameters:
- MESSAGE_LENGTH, 8: bits per word; must match the master.
- ACK_SLOT, 1: 1 means one extra scl pulse follows each word (acknowledge slot); 0 means no slot.
- SYNC_STAGES, 2: synchronizer flops on each of scl and sda; legal values are 2 or 3.

Ports:
- clk  input  1  system clock; at least 8x faster than scl.
- reset  input  1  synchronous, active-low reset.
- sda  input  1  I2C data line from the master.
- scl  input  1  I2C clock line from the master.
- data_out  output  MESSAGE_LENGTH  last completed word.
- data_valid  output  1  one-cycle pulse when data_out updates.
- busy  output  1  high between a START and the following STOP.
- frame_error  output  1  sticky; high when a START or STOP arrives mid-word.
- sda_ack_n  output  1  present only with ACK_DRIVE_EN (see Optional Feature).

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-low on port reset; it is sampled on the rising edge of clk.
- Reset values: data_out=0, data_valid=0, busy=0, frame_error=0, sda_ack_n=1, bit count=0, state=IDLE. Synchronizer flops reset to 1 (idle bus).
- Edge detection on synchronized signals (s_scl, s_sda, plus one-cycle-delayed copies):
  - scl_rise: s_scl 0 to 1.
  - scl_fall: s_scl 1 to 0.
  - START: s_sda 1 to 0 while s_scl is 1.
  - STOP: s_sda 0 to 1 while s_scl is 1.
- Bit sampling: on scl_rise in RECV, shift s_sda into the shift register LSB side, so the first received bit ends in the MSB. Increment count, width $clog2(MESSAGE_LENGTH+1).
- Latency: SYNC_STAGES+1 clk edges from the pin-level scl rise of the last bit to data_valid=1.
- FSM states and transitions:
  - IDLE: START leads to RECV; busy=1, count=0.
  - RECV: when count reaches MESSAGE_LENGTH, latch shift register into data_out, pulse data_valid, clear count. Then go to ACK if ACK_SLOT=1, else stay in RECV.
  - ACK: wait for one scl_rise followed by one scl_fall, then go to RECV.
  - STOP in any state: go to IDLE, busy=0. If taken in RECV with count not 0 and not MESSAGE_LENGTH, set frame_error and discard the partial word.
  - START while busy (repeated start): go to RECV, count=0. Set frame_error if count is not 0.
- Simultaneous events: START/STOP detection takes priority over scl_rise in the same cycle; no bit is sampled in that cycle.
- frame_error clears only on reset.
- Reset mid-word: the partial word is lost and no data_valid is issued.
- Back-to-back words need no gap: the first scl_rise after ACK (or directly after the last bit when ACK_SLOT=0) samples bit MSB of the next word.

Optional Feature:
- Macro: I2C_RX_ACK_DRIVE_EN.
- Defined:
  - Adds output sda_ack_n, an active-low open-drain request.
  - sda_ack_n is driven 0 from the first scl_fall after the last data bit until the scl_fall that ends the ACK slot; it is 1 otherwise.
  - Only meaningful with ACK_SLOT=1. An elaboration error is raised if ACK_SLOT=0.
- Undefined:
  - Port absent; the block never loads the bus.
  - The ACK slot is still counted if ACK_SLOT=1.

Decomposition:
- Package i2c_pkg holds:
  - the state enum (IDLE, RECV, ACK);
  - the default MESSAGE_LENGTH constant, shared with the master;
  - a localparam function for the count width.
- One sub-module, i2c_line_sync: SYNC_STAGES-flop synchronizer plus a delayed copy, with rise/fall outputs. Instantiated once for scl and once for sda.

Test Plan:
- Master sends START, 8'b01011111, ACK slot, STOP -> one data_valid pulse with data_out=8'h5F; busy high from START until STOP; frame_error=0.
- Back-to-back 8'b10010101, 8'b11110000, 8'b00001111 in one transaction -> three data_valid pulses in order with 8'h95, 8'hF0, 8'h0F; busy stays high throughout.
- STOP after 3 bits of 8'hA5 -> no data_valid; frame_error=1; busy=0; a following START with 8'h3C yields data_out=8'h3C, and frame_error stays 1.
- reset=0 asserted mid-word (after 5 bits), released, then a full 8'h81 is sent -> all outputs 0 during reset, then exactly one data_valid with 8'h81.
- With I2C_RX_ACK_DRIVE_EN defined, send 8'h5F -> sda_ack_n=0 exactly over the 9th scl pulse (from the fall after bit 8 to the next fall), 1 elsewhere.
- Repeated START after a full word (8'h12), then 8'h34 -> data_out 8'h12 then 8'h34; frame_error=0; busy never drops.
